// File: rtl/ex_logic_stage.sv
// Two-stage logic-unit EX pipeline: S1 latches the operation, S2 latches the result.
// Valid/ready handshake on both sides, flush and reset discard in-flight work.
module ex_logic_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic [4:0]       out_rd,
    output logic             out_zero,
    output logic [15:0]      retired
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpNor  = 3'b011,
        OpLui  = 3'b100,
        OpPassA = 3'b101,
        OpPassB = 3'b110,
        OpRsvd = 3'b111
    } op_e;

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [4:0]       s1_rd_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] out_q;
    logic [4:0]       out_rd_q;
    logic             out_zero_q;
    logic [15:0]      retired_q;

    logic             in_xfer;
    logic             out_xfer;
    logic             s1_adv;
    logic [WIDTH-1:0] result;

    always_comb begin
        out_xfer = s2_valid_q && out_ready;
        s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !rst && (!s1_valid_q || s1_adv);
        in_xfer  = in_valid && in_ready;
    end

    always_comb begin
        result = '0;
        unique case (op_e'(s1_op_q))
            OpAnd:   result = s1_a_q & s1_b_q;
            OpOr:    result = s1_a_q | s1_b_q;
            OpXor:   result = s1_a_q ^ s1_b_q;
            OpNor:   result = ~(s1_a_q | s1_b_q);
            OpLui:   result = {s1_b_q[15:0], {(WIDTH-16){1'b0}}};
            OpPassA: result = s1_a_q;
            OpPassB: result = s1_b_q;
            OpRsvd:  result = '0;
            default: result = '0;
        endcase
    end

    // Flush only kills the valid bits; data registers are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= op;
            s1_a_q     <= A;
            s1_b_q     <= B;
            s1_rd_q    <= rd;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            out_rd_q   <= '0;
            out_zero_q <= 1'b0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= 1'b1;
            out_q      <= result;
            out_rd_q   <= s1_rd_q;
            out_zero_q <= (result == '0);
        end else if (out_xfer) begin
            s2_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (out_xfer && !flush) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign out_valid = s2_valid_q;
    assign Out       = out_q;
    assign out_rd    = out_rd_q;
    assign out_zero  = out_zero_q;
    assign retired   = retired_q;

endmodule

// File: doc/ex_logic_stage.md
EX_LOGIC_STAGE -- requirements
Module: ex_logic_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width of operands and result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream (ID) presents an operation.
REQ-005 SHALL have port in_ready, output, 1, the stage accepts an operation this cycle.
REQ-006 SHALL have port op, input, 3, the operation select.
REQ-007 SHALL have ports A and B, inputs, WIDTH, the operands.
REQ-008 SHALL have port rd, input, 5, the destination register tag.
REQ-009 SHALL have port flush, input, 1, discards all in-flight operations.
REQ-010 SHALL have port out_valid, output, 1, a result is presented to MEM.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have ports Out (WIDTH), out_rd (5) and out_zero (1), outputs, carrying the result, its tag, and the flag for Out equal to zero.
REQ-013 SHALL have port retired, output, 16, the count of results delivered.

Function
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 SHALL be two registered stages: S1 holds op/A/B/rd; S2 holds Out/out_rd/out_zero. Result SHALL appear on out_valid exactly 2 cycles after input transfer when never stalled.
REQ-016 S1 SHALL advance into S2 when S1 is valid and (S2 is empty or S2 transfers this cycle).
REQ-017 in_ready SHALL equal (S1 empty) or (S1 advances this cycle), giving one operation per cycle at full throughput.
REQ-018 The op encodings SHALL be as follows.
- 000 AND
- 001 OR
- 010 XOR
- 011 NOR
- 100 LUI: {B[15:0], zeros}
- 101 pass A
- 110 pass B
- 111 reserved, result all zeros
The result SHALL be computed combinationally from S1 and captured into S2.
REQ-019 out_zero SHALL be 1 exactly when the captured Out equals 0.
REQ-020 While out_valid=1 and out_ready=0, Out, out_rd and out_zero SHALL hold stable, and no S1 content SHALL be lost or duplicated.
REQ-021 A flush SHALL take effect at the next edge: S1 and S2 become invalid, any input offered that cycle is dropped, and retired does not increment even if out_ready=1. Flush SHALL take priority over every transfer.
REQ-022 retired SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-023 S1 and S2 SHALL be simultaneously loadable and drainable in one cycle: S2 takes the S1 result while S2's old result transfers out.
REQ-024 Data registers SHALL load only on a valid transfer; in_valid=0 SHALL leave the stage contents unchanged.

Reset
REQ-025 With rst=1 at an edge, S1 and S2 SHALL become invalid, out_valid SHALL be 0, and Out, out_rd, out_zero and retired SHALL be 0.
REQ-026 in_ready SHALL be 0 while rst=1, and SHALL be 1 in the first cycle after rst is released.
REQ-027 rst asserted mid-operation SHALL discard in-flight operations exactly as a flush does, and SHALL also clear retired.

Verification
REQ-028 Reset then single op: op=010, A=0xFFFF0000, B=0x0F0F0F0F, rd=7, out_ready=1 -> 2 cycles later Out=0xF0F00F0F, out_rd=7, out_zero=0, retired=1.
REQ-029 Zero flag: op=010, A=B=0x12345678 -> Out=0, out_zero=1. Also op=100, B=0x0000ABCD -> Out=0xABCD0000.
REQ-030 Backpressure: stream 4 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepts and Out holds the first result. Raise out_ready -> all 4 results emerge in order with no loss or duplication, and retired=4.
REQ-031 Flush: two ops in flight, flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0 and no result appears for any of the 3 ops.
REQ-032 Wrap: preload retired to 0xFFFF via 65535 transfers, then 1 more transfer -> retired=0x0000.
REQ-033 Reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, Out=0, retired=0, in_ready=0. After release, in_ready=1.
